// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared word width, instruction field positions and fetch FSM encodings
package fetch_unit_pkg;

    localparam int DEF_WORD_SIZE = 16;

    // Instruction field positions decoded straight off IF/ID
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_BUF   = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bundle
interface fetch_unit_if #(
    parameter int WORD_SIZE = fetch_unit_pkg::DEF_WORD_SIZE
) ();

    logic                 i_mem_read;
    logic [WORD_SIZE-1:0] i_mem_addr;
    logic [WORD_SIZE-1:0] i_mem_data;
    logic                 i_mem_ready;

    modport master (
        output i_mem_read,
        output i_mem_addr,
        input  i_mem_data,
        input  i_mem_ready
    );

    modport slave (
        input  i_mem_read,
        input  i_mem_addr,
        output i_mem_data,
        output i_mem_ready
    );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with load, hold and clear
module if_id_reg #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic [WORD_SIZE-1:0] inst_i,
    input  logic [WORD_SIZE-1:0] pc1_i,
    output logic [WORD_SIZE-1:0] inst_o,
    output logic [WORD_SIZE-1:0] pc1_o,
    output logic                 valid_o
);

    logic [WORD_SIZE-1:0] inst_q;
    logic [WORD_SIZE-1:0] pc1_q;
    logic                 valid_q;

    // Clear only drops the valid bit; the stale word stays visible but is marked dead
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inst_q  <= '0;
            pc1_q   <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            inst_q  <= inst_i;
            pc1_q   <= pc1_i;
            valid_q <= 1'b1;
        end
    end

    assign inst_o  = inst_q;
    assign pc1_o   = pc1_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM, PC and stall buffer; FETCH_STATS_EN adds the num_fetch counter
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   WORD_SIZE = DEF_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fetch_unit_if.master         imem,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic [WORD_SIZE-1:0] if_id_inst,
    output logic [WORD_SIZE-1:0] if_id_pc1,
    output logic                 if_id_valid,
    output logic [3:0]           opcode,
    output logic [5:0]           func_code,
`ifdef FETCH_STATS_EN
    output logic [WORD_SIZE-1:0] num_fetch,
`endif
    output logic                 halted
);

    fetch_state_e         state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] buf_inst_q, buf_inst_d;
    logic [WORD_SIZE-1:0] buf_pc1_q, buf_pc1_d;
    logic [WORD_SIZE-1:0] pc_plus1;
    logic                 ifid_load;
    logic                 ifid_clear;
    logic [WORD_SIZE-1:0] ifid_inst_d;
    logic [WORD_SIZE-1:0] ifid_pc1_d;

    assign pc_plus1 = pc_q + WORD_SIZE'(1);

    // Next-state: HALT is sticky, flush beats halt, halt beats stall/ready
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_inst_d  = buf_inst_q;
        buf_pc1_d   = buf_pc1_q;
        ifid_load   = 1'b0;
        ifid_clear  = 1'b0;
        ifid_inst_d = imem.i_mem_data;
        ifid_pc1_d  = pc_plus1;
        if (state_q != ST_HALT) begin
            if (flush) begin
                ifid_clear = 1'b1;
                pc_d       = redirect_pc;
                buf_inst_d = '0;
                buf_pc1_d  = '0;
                state_d    = ST_FETCH;
            end else if (halt) begin
                state_d = ST_HALT;
            end else if (state_q == ST_BUF) begin
                if (!stall) begin
                    ifid_load   = 1'b1;
                    ifid_inst_d = buf_inst_q;
                    ifid_pc1_d  = buf_pc1_q;
                    pc_d        = buf_pc1_q;
                    state_d     = ST_FETCH;
                end
            end else if (imem.i_mem_ready) begin
                if (stall) begin
                    buf_inst_d = imem.i_mem_data;
                    buf_pc1_d  = pc_plus1;
                    state_d    = ST_BUF;
                end else begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus1;
                end
            end else if (!stall) begin
                // No word arrived and decode is free: pass a bubble down
                ifid_clear = 1'b1;
            end
        end
    end

    // State, PC and stall buffer registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            buf_inst_q <= '0;
            buf_pc1_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_inst_q <= buf_inst_d;
            buf_pc1_q  <= buf_pc1_d;
        end
    end

    if_id_reg #(.WORD_SIZE(WORD_SIZE)) u_if_id_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (ifid_load),
        .clear_i (ifid_clear),
        .inst_i  (ifid_inst_d),
        .pc1_i   (ifid_pc1_d),
        .inst_o  (if_id_inst),
        .pc1_o   (if_id_pc1),
        .valid_o (if_id_valid)
    );

`ifdef FETCH_STATS_EN
    logic [WORD_SIZE-1:0] num_fetch_q;

    // Count every word that actually lands in IF/ID
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_fetch_q <= '0;
        end else if (ifid_load) begin
            num_fetch_q <= num_fetch_q + WORD_SIZE'(1);
        end
    end

    assign num_fetch = num_fetch_q;
`endif

    assign imem.i_mem_read = (state_q == ST_FETCH);
    assign imem.i_mem_addr = pc_q;
    assign halted          = (state_q == ST_HALT);
    assign opcode          = if_id_inst[OPCODE_MSB:OPCODE_LSB];
    assign func_code       = if_id_inst[FUNC_MSB:FUNC_LSB];

endmodule
